// File: rtl/axi_burst_pkg.sv
// axi_burst_pkg: shared state encoding and AXI constants for the burst master
package axi_burst_pkg;
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA, DONE} state_t;
    localparam int         BEAT_BYTES     = 64;
    localparam logic [2:0] AXSIZE_512     = 3'd6;
    localparam logic [1:0] BURST_INCR     = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam int         BOUNDARY_BEATS = 64;
endpackage

// File: rtl/axi_burst_splitter.sv
// axi_burst_splitter: sizes the next INCR burst so it never crosses a 4 KB page
// beat_idx  : beat position of the burst start inside its 4 KB page (addr[11:6])
// remaining : beats still owed for the command
// beats     : beats in this burst, min(remaining, beats left in the page)
// axlen     : beats - 1, for AWLEN/ARLEN
module axi_burst_splitter
    import axi_burst_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic [5:0]     beat_idx,
    input  logic [LEN_W:0] remaining,
    output logic [LEN_W:0] beats,
    output logic [7:0]     axlen
);
    localparam int CW = LEN_W + 1;
    logic [CW-1:0] room;
    assign room  = CW'(BOUNDARY_BEATS) - CW'(beat_idx);
    assign beats = (remaining < room) ? remaining : room;
    assign axlen = 8'(beats - CW'(1));
endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: AXI4 INCR burst master driven by a local command port
// m_axi_aclk/m_axi_aresetn : clock, asynchronous active-low reset
// cmd_*                    : command (write/read, start address, beats-1), cmd_ready when idle
// wr_*                     : write payload stream, passed through to the W channel
// rd_*                     : read payload stream from the R channel, rd_last on the command's final beat
// done/err                 : one-cycle completion pulse, err if any response was not OKAY
// m_axi_aw/w/b/ar/r*       : AXI4 master channels toward the BRAM slave
module axi_burst_master
    import axi_burst_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 512,
    parameter int LEN_W  = 8
) (
    input  logic                m_axi_aclk,
    input  logic                m_axi_aresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arlock,
    output logic [3:0]          m_axi_arcache,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);
    localparam int CW = LEN_W + 1;
    state_t            state_q, state_d;
    logic              wr_q, err_q, err_set;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     rem_q, beat_q, beats;
    logic [7:0]        axlen;
    logic              accept, w_fire, r_fire, last_beat, last_burst, burst_end;

    axi_burst_splitter #(.LEN_W(LEN_W)) u_split (
        .beat_idx (addr_q[11:6]),
        .remaining(rem_q),
        .beats    (beats),
        .axlen    (axlen)
    );

    assign accept     = cmd_valid && cmd_ready;
    assign w_fire     = m_axi_wvalid && m_axi_wready;
    assign r_fire     = m_axi_rvalid && m_axi_rready;
    assign last_beat  = beat_q == beats - CW'(1);
    assign last_burst = rem_q == beats;
    assign burst_end  = (state_q == WRESP && m_axi_bvalid) || (r_fire && m_axi_rlast);
    // a slave rlast that disagrees with our own beat count is reported as an error
    assign err_set    = (state_q == WRESP && m_axi_bvalid && m_axi_bresp != RESP_OKAY) ||
                        (r_fire && (m_axi_rresp != RESP_OKAY || m_axi_rlast != last_beat));

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awlen   = axlen;
    assign m_axi_arlen   = axlen;
    assign m_axi_awsize  = AXSIZE_512;
    assign m_axi_arsize  = AXSIZE_512;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = state_q == ADDR && wr_q;
    assign m_axi_arvalid = state_q == ADDR && !wr_q;
    assign m_axi_wvalid  = state_q == WDATA && wr_valid;
    assign wr_ready      = state_q == WDATA && m_axi_wready;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = last_beat;
    assign m_axi_bready  = state_q == WRESP;
    assign m_axi_rready  = state_q == RDATA && rd_ready;
    assign rd_valid      = state_q == RDATA && m_axi_rvalid;
    assign rd_data       = m_axi_rdata;
    assign rd_last       = rd_valid && m_axi_rlast && last_burst;
    assign done          = state_q == DONE;
    assign err           = done && err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ADDR : IDLE;
            ADDR:    state_d = wr_q ? (m_axi_awready ? WDATA : ADDR) : (m_axi_arready ? RDATA : ADDR);
            WDATA:   state_d = (w_fire && last_beat) ? WRESP : WDATA;
            WRESP:   state_d = m_axi_bvalid ? (last_burst ? DONE : ADDR) : WRESP;
            RDATA:   state_d = (r_fire && m_axi_rlast) ? (last_burst ? DONE : ADDR) : RDATA;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            rem_q     <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= state_d == IDLE;
            if (accept) begin
                wr_q   <= cmd_wr;
                addr_q <= cmd_addr & ~ADDR_W'(BEAT_BYTES - 1);
                rem_q  <= CW'(cmd_len) + CW'(1);
            end
            if (w_fire || r_fire)
                beat_q <= ((w_fire && last_beat) || (r_fire && m_axi_rlast)) ? '0 : beat_q + CW'(1);
            if (burst_end) begin
                addr_q <= addr_q + ADDR_W'(beats) * ADDR_W'(BEAT_BYTES);
                rem_q  <= rem_q - beats;
            end
            err_q <= (state_q == DONE) ? 1'b0 : (err_q | err_set);
        end
    end
endmodule
